fdiv_iter: RTL and testbench
============================

// Module: fdiv_iter
// PURPOSE
//  Iterative IEEE-754 floating-point divider, q = a / b, one quotient bit per clock.
//  Replaces the fixed-latency combinational divide with a radix-2 restoring divider behind
//  valid/ready handshakes. Sits in the FPU beside the other falu units.
//  Adds full special-case handling, exception flags and optional round-to-nearest-even.
// PARAMETERS
//  DATAW  32  total word width (= 1 + EXPW + MANW)
//  EXPW   8   exponent field width; BIAS = 2^(EXPW-1)-1
//  MANW   23  stored mantissa width; hidden bit implied
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      a/b valid
//  in_ready   out  1      unit can accept an operation (high only in IDLE)
//  a          in   DATAW  dividend
//  b          in   DATAW  divisor
//  out_valid  out  1      q/flags valid
//  out_ready  in   1      consumer takes the result
//  q          out  DATAW  quotient
//  flags      out  4      {nv invalid, dz div-by-zero, of overflow, uf underflow}
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, q=0, flags=0. Applies immediately, also mid-op.
//    An operation in flight is dropped with no output.
//  FSM: IDLE -> (in_valid) latch a,b; special -> DONE, else -> DIVIDE.
//    DIVIDE runs MANW+3 iterations -> ROUND (1 cycle) -> DONE.
//    DONE holds q/flags stable with out_valid=1 until out_ready=1, then -> IDLE.
//  Latency (accept edge to out_valid): special cases 1 cycle; normal MANW+4 cycles (27 default).
//    Throughput is one op per latency+1 cycles minimum; in_ready=0 outside IDLE.
//  Decode: exp==0 means zero (denormal inputs flush to signed zero).
//    exp==all-ones with man==0 is inf; with man!=0 is NaN.
//  Sign: sa^sb for every non-NaN result.
//  Special-case priority:
//    - any NaN, 0/0, or inf/inf -> 0x7FC00000 canonical qNaN (generic: 0,1s,1,0s); nv=1 except NaN input
//    - x/0, x finite nonzero -> signed inf, dz=1
//    - inf/x -> signed inf
//    - 0/x or x/inf -> signed zero; no flags
//  Divide: rem = {0,1.ma} (MANW+2 bits), div = {0,1.mb}.
//    Each iteration: if rem>=div then {bit=1; rem-=div} else bit=0; rem<<=1.
//    quotient register qr gets MANW+3 bits shifted in MSB first.
//    sticky = |rem after the last iteration.
//  Exponent: e = ea - eb + BIAS, signed EXPW+2 bits.
//    If qr MSB==0 (ma<mb): use qr[MANW+1:0] and e -= 1.
//    Either way take MANW+1 significant bits plus one round bit; bits shifted out OR into sticky.
//  ROUND: see CONFIGURATION. Carry out to 2.0 -> mantissa=1.0, e += 1.
//  Range checks (after rounding):
//    - e >= 2^EXPW-1 -> signed inf, of=1
//    - e <= 0 -> signed zero, uf=1 (no denormal output)
//  flags are only meaningful while out_valid=1. They are held with q and cleared on leaving DONE.
//  in_valid while in_ready=0 is ignored; the producer must hold it.
// CONFIGURATION
//  FDIV_RNE_EN defined: round-to-nearest-even.
//    Increment if round & (sticky | lsb).
//  FDIV_RNE_EN undefined: truncate toward zero.
//    Round bit and sticky are discarded; no carry-out possible.
//  Latency and flags are identical in both builds.
// TESTING
//  1. a=0x40C00000 (6.0), b=0x40000000 (2.0) -> q=0x40400000, flags=0, out_valid 27 cycles after accept.
//  2. a=0x3F800000, b=0x40400000 (1/3) -> q=0x3EAAAAAB with FDIV_RNE_EN, 0x3EAAAAAA without.
//  3. a=0xBF800000, b=0x00000000 -> q=0xFF800000, flags=0100, out_valid 1 cycle after accept.
//     a=b=0 -> q=0x7FC00000, flags=1000.
//  4. a=0x7F000000, b=0x3E800000 -> q=0x7F800000, of=1.
//     a=0x00800000, b=0x4B000000 -> q=0x00000000, uf=1.
//  5. Hold out_ready=0 for 10 cycles in DONE -> q/flags/out_valid stable, in_ready=0.
//     Then out_ready=1 -> in_ready=1 next cycle; back-to-back op accepted correctly.
//  6. Assert rst_n=0 in iteration 10 -> outputs reset asynchronously, no out_valid.
//     A new op after release gives the correct result.

Source files
------------

// File: rtl/fdiv_iter_if.sv
// Handshake bundle for fdiv_iter: operand request side and result side.
interface fdiv_iter_if #(
    parameter int DATAW = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] a;
    logic [DATAW-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] q;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, flags
    );
endinterface

// File: rtl/fdiv_iter.sv
// Iterative radix-2 restoring IEEE-754 divider, one quotient bit per clock.
// Define FDIV_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fdiv_iter #(
    parameter int DATAW = 32,
    parameter int EXPW  = 8,
    parameter int MANW  = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    fdiv_iter_if.slave  bus
);
    localparam int EW   = EXPW + 2;
    localparam int SW   = MANW + 2;
    localparam int QW   = MANW + 3;
    localparam int CW   = $clog2(QW + 1);
    localparam int BIAS = 2**(EXPW-1) - 1;
    localparam logic signed [EW-1:0] EMAX = EW'(2**EXPW - 1);
`ifdef FDIV_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;
    state_t state_q, state_d;

    logic                 sign_q, sign_d;
    logic signed [EW-1:0] e_q, e_d;
    logic [SW-1:0]        rem_q, rem_d, div_q, div_d;
    logic [QW-1:0]        qr_q, qr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATAW-1:0]     q_q, q_d;
    logic [3:0]           flags_q, flags_d;

    logic                 sa, sb, s;
    logic [EXPW-1:0]      ea, eb;
    logic [MANW-1:0]      ma, mb;
    logic                 za, zb, ia, ib, na, nb;
    logic                 spec;
    logic [DATAW-1:0]     spec_q;
    logic [3:0]           spec_f;
    logic signed [EW-1:0] e0;

    assign sa = bus.a[DATAW-1];
    assign sb = bus.b[DATAW-1];
    assign ea = bus.a[DATAW-2 -: EXPW];
    assign eb = bus.b[DATAW-2 -: EXPW];
    assign ma = bus.a[MANW-1:0];
    assign mb = bus.b[MANW-1:0];
    assign s  = sa ^ sb;
    assign za = (ea == '0);
    assign zb = (eb == '0);
    assign ia = (ea == '1) && (ma == '0);
    assign ib = (eb == '1) && (mb == '0);
    assign na = (ea == '1) && (ma != '0);
    assign nb = (eb == '1) && (mb != '0);
    assign e0 = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EW'(BIAS);

    always_comb begin
        spec   = 1'b1;
        spec_q = '0;
        spec_f = '0;
        if (na || nb || (za && zb) || (ia && ib)) begin
            spec_q = {1'b0, {EXPW{1'b1}}, 1'b1, {(MANW-1){1'b0}}};
            spec_f = {!(na || nb), 3'b000};
        end else if (zb && !ia) begin
            spec_q = {s, {EXPW{1'b1}}, {MANW{1'b0}}};
            spec_f = 4'b0100;
        end else if (ia) begin
            spec_q = {s, {EXPW{1'b1}}, {MANW{1'b0}}};
        end else if (za || ib) begin
            spec_q = {s, {(DATAW-1){1'b0}}};
        end else begin
            spec = 1'b0;
        end
    end

    // The first iteration runs on the accept edge straight from the operands,
    // so DIVIDE only needs QW-1 further cycles for the full QW bits.
    logic [SW-1:0] rem_src, div_src, rem_nxt;
    logic          ge;
    assign rem_src = (state_q == IDLE) ? {2'b01, ma} : rem_q;
    assign div_src = (state_q == IDLE) ? {2'b01, mb} : div_q;
    assign ge      = (rem_src >= div_src);
    assign rem_nxt = (ge ? rem_src - div_src : rem_src) << 1;

    logic [MANW-1:0]      frac_pre, frac;
    logic                 rb, st, lsb, inc, carry, of, uf;
    logic signed [EW-1:0] e_adj, e_r;
    logic [DATAW-1:0]     res;

    always_comb begin
        if (qr_q[QW-1]) begin
            frac_pre = qr_q[QW-2:2];
            rb       = qr_q[1];
            st       = qr_q[0] | (|rem_q);
            e_adj    = e_q;
        end else begin
            frac_pre = qr_q[QW-3:1];
            rb       = qr_q[0];
            st       = |rem_q;
            e_adj    = e_q - EW'(1);
        end
        lsb            = frac_pre[0];
        inc            = RNE & rb & (st | lsb);
        {carry, frac}  = {1'b0, frac_pre} + {{MANW{1'b0}}, inc};
        e_r            = carry ? e_adj + EW'(1) : e_adj;
        of             = (e_r >= EMAX);
        uf             = e_r[EW-1] || (e_r == '0);
        if (of)      res = {sign_q, {EXPW{1'b1}}, {MANW{1'b0}}};
        else if (uf) res = {sign_q, {(DATAW-1){1'b0}}};
        else         res = {sign_q, e_r[EXPW-1:0], frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = spec ? DONE : DIVIDE;
            DIVIDE:  if (cnt_q == CW'(QW-1)) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.q         = q_q;
        bus.flags     = flags_q;
    end

    always_comb begin
        sign_d  = sign_q;
        e_d     = e_q;
        rem_d   = rem_q;
        div_d   = div_q;
        qr_d    = qr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                sign_d = s;
                if (spec) begin
                    q_d     = spec_q;
                    flags_d = spec_f;
                end else begin
                    e_d   = e0;
                    rem_d = rem_nxt;
                    div_d = div_src;
                    qr_d  = {{(QW-1){1'b0}}, ge};
                    cnt_d = CW'(1);
                end
            end
            DIVIDE: begin
                rem_d = rem_nxt;
                qr_d  = {qr_q[QW-2:0], ge};
                cnt_d = cnt_q + CW'(1);
            end
            ROUND: begin
                q_d     = res;
                flags_d = {2'b00, of, uf};
            end
            DONE:    if (bus.out_ready) flags_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q  <= 1'b0;
            e_q     <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            qr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            flags_q <= '0;
        end else begin
            sign_q  <= sign_d;
            e_q     <= e_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            qr_q    <= qr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter: vector table plus backpressure and mid-op reset sequences.
module tb_fdiv_iter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fdiv_iter_if #(.DATAW(32)) bus ();

    fdiv_iter #(.DATAW(32), .EXPW(8), .MANW(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef FDIV_RNE_EN
    localparam logic [31:0] Q_1_3 = 32'h3EAAAAAB;
    localparam logic [31:0] Q_2_3 = 32'h3F2AAAAB;
`else
    localparam logic [31:0] Q_1_3 = 32'h3EAAAAAA;
    localparam logic [31:0] Q_2_3 = 32'h3F2AAAAA;
`endif

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vq[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [3:0] f, input int lat);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.q = q; v.f = f; v.lat = lat;
        vq.push_back(v);
    endtask

    // Called at a negedge; returns at the first negedge where out_valid is high.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv,
                          output logic [31:0] rq, output logic [3:0] rf, output int lat);
        int guard;
        bus.a        = ta;
        bus.b        = tbv;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 200);
        rq = bus.q;
        rf = bus.flags;
    endtask

    task automatic release_op();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rq;
        logic [3:0]  rf;
        int          lat;
        int          seen;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        add("6/2",        32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
        add("1/3",        32'h3F800000, 32'h40400000, Q_1_3,        4'b0000, 27);
        add("2/3",        32'h40000000, 32'h40400000, Q_2_3,        4'b0000, 27);
        add("-6/2",       32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 27);
        add("1/1",        32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 27);
        add("-1/0",       32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 1);
        add("0/0",        32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
        add("nan/0",      32'h7FC00001, 32'h00000000, 32'h7FC00000, 4'b0000, 1);
        add("nan/1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 1);
        add("inf/-inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1);
        add("inf/0",      32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000, 1);
        add("-inf/2",     32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
        add("-0/1",       32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1);
        add("1/-inf",     32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 1);
        add("denorm/1",   32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1);
        add("ovf",        32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 27);
        add("ovf_edge",   32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 27);
        add("max_exp",    32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 27);
        add("unf",        32'h00800000, 32'h4B000000, 32'h00000000, 4'b0001, 27);
        add("unf_edge",   32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 27);
        add("min_norm",   32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 27);

        #2 rst_n = 1'b0;
        #1 check("reset_state", {bus.in_ready, bus.out_valid, bus.flags, bus.q},
                 {1'b1, 1'b0, 4'b0000, 32'h0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vq[i]) begin
            run_op(vq[i].a, vq[i].b, rq, rf, lat);
            check({vq[i].name, "_q"},     rq,  vq[i].q);
            check({vq[i].name, "_flags"}, rf,  vq[i].f);
            check({vq[i].name, "_lat"},   lat, vq[i].lat);
            release_op();
        end

        // Flags are dropped when the result leaves DONE.
        run_op(32'hBF800000, 32'h00000000, rq, rf, lat);
        release_op();
        check("flags_cleared_idle", {bus.in_ready, bus.flags}, {1'b1, 4'b0000});

        // Backpressure: result must sit still while out_ready is low.
        run_op(32'h40C00000, 32'h40000000, rq, rf, lat);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_done", {bus.out_valid, bus.in_ready, bus.flags, bus.q},
                  {1'b1, 1'b0, 4'b0000, 32'h40400000});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("ready_after_take", {bus.in_ready, bus.out_valid}, {1'b1, 1'b0});
        run_op(32'h3F800000, 32'h40400000, rq, rf, lat);
        check("b2b_q",   rq,  Q_1_3);
        check("b2b_lat", lat, 27);
        release_op();

        // Reset in the middle of an iteration sequence.
        bus.a        = 32'h40C00000;
        bus.b        = 32'h40000000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        #1 check("mid_reset", {bus.in_ready, bus.out_valid, bus.flags, bus.q},
                 {1'b1, 1'b0, 4'b0000, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("no_out_after_reset", seen, 0);
        run_op(32'h40000000, 32'h40400000, rq, rf, lat);
        check("post_reset_q",     rq,  Q_2_3);
        check("post_reset_flags", rf,  4'b0000);
        check("post_reset_lat",   lat, 27);
        release_op();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
